// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and types shared by the I2S transmit feeder blocks.
//   I2S_W          sample width
//   I2S_SLOT_BITS  bclk periods per channel slot
//   state_t        feeder run state
//   LEFT / RIGHT   lrclk encoding of the slot side
package i2s_pkg;
   localparam int I2S_W         = 16;
   localparam int I2S_SLOT_BITS = 16;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;
endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: synchronous show-ahead FIFO for the sample feeder.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (flushes contents)
//   push, din      write request and data (ignored when full)
//   pop            read request (ignored when empty)
//   dout           current head word, valid whenever !empty
//   full, empty    occupancy flags
//   level          current occupancy, 0..DEPTH
module i2s_sample_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/i2s_sample_feeder.sv
// i2s_sample_feeder: buffers stereo samples, generates bclk/lrclk and hands
// one word per 16-bit slot to the downstream MSB-first shifter.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   enable              level-sensitive run request
//   s_data/s_valid/s_ready  producer handshake (left, right, left, ...)
//   bclk, lrclk         registered serial clocks (lrclk 0 = left)
//   word_out, word_load slot word and its one-cycle load strobe
//   underrun            one-cycle pulse: slot started with an empty FIFO
//   fifo_level          FIFO occupancy
// Build option: I2S_FEED_HOLD_LAST_EN -- on underrun repeat the last word
// loaded for the same channel instead of sending silence.
module i2s_sample_feeder
   import i2s_pkg::*;
#(
   parameter int DIV        = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int W          = I2S_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [W-1:0]                  s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          bclk,
   output logic                          lrclk,
   output logic [W-1:0]                  word_out,
   output logic                          word_load,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
   localparam logic [3:0] SLOT_LAST = 4'(I2S_SLOT_BITS - 1);

   state_t       state, state_next;
   logic [7:0]   half_cnt;
   logic [3:0]   bit_cnt;
   logic         first_slot;   // next falling edge is the first slot after IDLE
   logic         tick;
   logic         fall_evt;
   logic         frame_end;
   logic         slot_start;
   logic         slot_side;
   logic [W-1:0] fifo_dout;
   logic [W-1:0] fill_word;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_pop;

   assign s_ready  = !fifo_full;
   assign fifo_pop = slot_start && !fifo_empty;

   i2s_sample_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (s_valid),
      .pop   (fifo_pop),
      .din   (s_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      tick       = (state != IDLE) && (half_cnt == DIV_LAST);
      fall_evt   = tick && bclk;
      // The frame ends on the falling edge that closes the right slot.
      frame_end  = fall_evt && (state == DRAIN) && !enable && !first_slot &&
                   (bit_cnt == SLOT_LAST) && (lrclk == RIGHT);
      slot_start = fall_evt && !frame_end && (first_slot || bit_cnt == SLOT_LAST);
      slot_side  = first_slot ? LEFT : ~lrclk;
      case (state)
         IDLE:    if (enable) state_next = RUN;
         RUN:     if (!enable) state_next = DRAIN;
         DRAIN: begin
            if (enable)         state_next = RUN;
            else if (frame_end) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef I2S_FEED_HOLD_LAST_EN
   // Last word loaded per channel, indexed by lrclk side.
   logic [W-1:0] hist [2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist[0] <= '0;
         hist[1] <= '0;
      end else if (fifo_pop) begin
         hist[slot_side] <= fifo_dout;
      end
   end

   assign fill_word = hist[slot_side];
`else
   assign fill_word = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         half_cnt   <= '0;
         bclk       <= 1'b0;
         bit_cnt    <= '0;
         lrclk      <= LEFT;
         first_slot <= 1'b1;
         word_out   <= '0;
         word_load  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         word_load <= slot_start;
         underrun  <= slot_start && fifo_empty;
         if (slot_start) begin
            lrclk    <= slot_side;
            word_out <= fifo_empty ? fill_word : fifo_dout;
         end
         if (state == IDLE || frame_end) begin
            half_cnt   <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= '0;
            lrclk      <= LEFT;
            first_slot <= 1'b1;
         end else begin
            if (tick) begin
               half_cnt <= '0;
               bclk     <= ~bclk;
            end else begin
               half_cnt <= half_cnt + 8'd1;
            end
            if (fall_evt) begin
               // The first falling edge opens slot bit 0 rather than advancing.
               bit_cnt    <= first_slot ? 4'd0 : bit_cnt + 4'd1;
               first_slot <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// tb_i2s_sample_feeder: self-checking bench for i2s_sample_feeder
// (DIV=4, FIFO_DEPTH=4). Directed table and sequences, then randomized
// traffic against a timeline model of the frame.
module tb_i2s_sample_feeder;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;
   localparam int W     = 16;
`ifdef I2S_FEED_HOLD_LAST_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset, enable, s_valid;
   logic [W-1:0] s_data;
   logic         s_ready, bclk, lrclk, word_load, underrun;
   logic [W-1:0] word_out;
   logic [2:0]   fifo_level;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   i2s_sample_feeder #(.DIV(DIV), .FIFO_DEPTH(DEPTH), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .word_out   (word_out),
      .word_load  (word_load),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic push1(input logic [W-1:0] d);
      s_valid = 1'b1; s_data = d;
      cyc();
      s_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_bclk"},  bclk, 0);
      chk({tag, "_lrclk"}, lrclk, 0);
      chk({tag, "_word"},  word_out, 0);
      chk({tag, "_load"},  word_load, 0);
      chk({tag, "_undr"},  underrun, 0);
      chk({tag, "_rdy"},   s_ready, 1);
      chk({tag, "_lvl"},   fifo_level, 0);
   endtask

   typedef struct {
      logic         valid;
      logic [W-1:0] data;
      int           lvl;
      logic         rdy;
   } vec_t;

   vec_t fill_tbl[5];

   // reference model state for the random run
   logic [W-1:0] q[$];
   logic [W-1:0] hist[2];
   logic [W-1:0] exp_word;
   logic         exp_lr, exp_load, exp_und, exp_bclk;
   bit           run_m, en_prev, push;
   int           t, k, prob, loads;
   int           probs[4] = '{0, 2, 30, 90};

   initial begin
      fill_tbl[0] = '{1'b1, 16'hA5A5, 1, 1'b1};
      fill_tbl[1] = '{1'b1, 16'h5A5A, 2, 1'b1};
      fill_tbl[2] = '{1'b1, 16'h1111, 3, 1'b1};
      fill_tbl[3] = '{1'b1, 16'h2222, 4, 1'b0};
      fill_tbl[4] = '{1'b1, 16'h3333, 4, 1'b0};   // held off: FIFO full

      reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      #12;
      chk_reset_vals("rst");
      cyc();
      reset = 1'b0;

      // FIFO fill with enable low
      for (int i = 0; i < 5; i++) begin
         s_valid = fill_tbl[i].valid;
         s_data  = fill_tbl[i].data;
         cyc();
         chk($sformatf("fill%0d_lvl", i), fifo_level, fill_tbl[i].lvl);
         chk($sformatf("fill%0d_rdy", i), s_ready, fill_tbl[i].rdy);
         chk($sformatf("fill%0d_bclk", i), bclk, 0);
      end

      // run, then drop enable mid-left-slot
      enable = 1'b1;
      loads = 0;
      for (int c = 0; c <= 540; c++) begin
         cyc();
         if (c == 3)   chk("bclk_lo3", bclk, 0);
         if (c == 4)   chk("bclk_rise4", bclk, 1);
         if (c == 12)  chk("bclk_rise12", bclk, 1);
         if (c == 7)   chk("load7", word_load, 0);
         if (c == 8) begin
            chk("load8", word_load, 1);
            chk("word8", word_out, 16'hA5A5);
            chk("lr8", lrclk, 0);
            chk("bclk8", bclk, 0);
            chk("lvl8", fifo_level, 3);
            chk("undr8", underrun, 0);
         end
         if (c == 9) begin
            chk("held_push_lvl9", fifo_level, 4);
            chk("load9", word_load, 0);
            s_valid = 1'b0;
         end
         if (c == 135) chk("lr135", lrclk, 0);
         if (c == 136) begin
            chk("load136", word_load, 1);
            chk("word136", word_out, 16'h5A5A);
            chk("lr136", lrclk, 1);
         end
         if (c == 264) chk("word264", word_out, 16'h1111);
         if (c == 300) enable = 1'b0;
         if (c > 300 && word_load) loads++;
         if (c == 392) begin
            chk("drain_load392", word_load, 1);
            chk("drain_word392", word_out, 16'h2222);
            chk("drain_lr392", lrclk, 1);
         end
         if (c == 519) chk("drain_bclk519", bclk, 1);
         if (c == 520) begin
            chk("end_bclk520", bclk, 0);
            chk("end_lr520", lrclk, 0);
            chk("end_load520", word_load, 0);
         end
         if (c == 524 || c == 540) chk($sformatf("idle_bclk%0d", c), bclk, 0);
      end
      chk("drain_loads", loads, 1);
      chk("drain_lvl", fifo_level, 1);

      // reset mid-slot with samples queued
      push1(16'h4444); push1(16'h5555); push1(16'h6666);
      chk("pre_rst_lvl", fifo_level, 4);
      enable = 1'b1;
      for (int c = 0; c <= 21; c++) begin
         cyc();
         if (c == 8)  chk("rst_run_word8", word_out, 16'h3333);
         if (c == 21) chk("rst_run_bclk21", bclk, 1);
      end
      #3 reset = 1'b1;
      #1 chk_reset_vals("midrst");
      cyc();
      reset = 1'b0;
      for (int c = 0; c <= 9; c++) begin
         cyc();
         if (c == 8) begin
            chk("post_rst_undr8", underrun, 1);
            chk("post_rst_load8", word_load, 1);
            chk("post_rst_word8", word_out, 0);
            chk("post_rst_lr8", lrclk, 0);
         end
         if (c == 9) chk("post_rst_undr9", underrun, 0);
      end

      // underrun fill word per channel
      do_reset();
      push1(16'h1234); push1(16'h0BCD);
      enable = 1'b1;
      for (int c = 0; c <= 392; c++) begin
         cyc();
         if (c == 8)   chk("hold_word8", word_out, 16'h1234);
         if (c == 136) chk("hold_word136", word_out, 16'h0BCD);
         if (c == 264) begin
            chk("hold_undr264", underrun, 1);
            chk("hold_lr264", lrclk, 0);
            chk("hold_word264", word_out, HOLD ? 16'h1234 : 16'h0000);
         end
         if (c == 392) begin
            chk("hold_undr392", underrun, 1);
            chk("hold_word392", word_out, HOLD ? 16'h0BCD : 16'h0000);
         end
      end

      // push and pop on the same edge at level 2
      do_reset();
      push1(16'h0A01); push1(16'h0A02);
      enable = 1'b1;
      for (int c = 0; c <= 136; c++) begin
         cyc();
         if (c == 7) begin s_valid = 1'b1; s_data = 16'h0A03; end
         if (c == 8) begin
            chk("pp_lvl8", fifo_level, 2);
            chk("pp_word8", word_out, 16'h0A01);
            chk("pp_load8", word_load, 1);
            s_valid = 1'b0;
         end
         if (c == 136) chk("pp_word136", word_out, 16'h0A02);
      end

      // randomized traffic against the frame timeline model
      do_reset();
      q.delete();
      hist[0] = '0; hist[1] = '0;
      exp_word = '0; exp_lr = 1'b0; exp_bclk = 1'b0;
      run_m = 1'b0; en_prev = 1'b0; t = 0; prob = 0;
      enable = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 0) prob = probs[(n / 500) % 4];
         if (n > 0) begin
            if (enable) begin
               if ($urandom_range(0, 399) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
               enable = 1'b1;
            end
         end
         s_valid = ($urandom_range(0, 99) < prob);
         s_data  = 16'($urandom);
         push    = s_valid && (q.size() < DEPTH);
         @(posedge clk);
         exp_load = 1'b0;
         exp_und  = 1'b0;
         if (!run_m) begin
            if (enable) begin run_m = 1'b1; t = 0; end
         end else begin
            t++;
            if (t >= 2*DIV && (t - 2*DIV) % (32*DIV) == 0) begin
               k = (t - 2*DIV) / (32*DIV);
               if (k % 2 == 0 && k > 0 && !enable && !en_prev) begin
                  run_m  = 1'b0;
                  exp_lr = 1'b0;
               end else begin
                  exp_lr   = (k % 2 == 1);
                  exp_load = 1'b1;
                  if (q.size() > 0) begin
                     exp_word       = q.pop_front();
                     hist[k % 2]    = exp_word;
                  end else begin
                     exp_und  = 1'b1;
                     exp_word = HOLD ? hist[k % 2] : '0;
                  end
               end
            end
         end
         en_prev = enable;
         if (push) q.push_back(s_data);
         exp_bclk = run_m ? ((t / DIV) % 2 == 1) : 1'b0;
         #1;
         chk("rnd_bclk",  bclk, exp_bclk);
         chk("rnd_lrclk", lrclk, exp_lr);
         chk("rnd_load",  word_load, exp_load);
         chk("rnd_undr",  underrun, exp_und);
         chk("rnd_word",  word_out, exp_word);
         chk("rnd_lvl",   fifo_level, q.size());
         chk("rnd_rdy",   s_ready, q.size() < DEPTH);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/i2s_sample_feeder.md
# i2s_sample_feeder

Upstream stage of the I2S transmit path. Buffers 16-bit stereo samples from the audio producer in a small FIFO, generates the serial bit clock (bclk) and word select (lrclk) from the system clock, and presents one sample word per 16-bit slot to the downstream parallel-to-serial shifter. The shifter shifts MSB-first on falling bclk.

## Interface
- DIV, 4: system clocks per bclk half-period; legal range 2..255.
- FIFO_DEPTH, 4: sample FIFO depth; power of two, 2..16.
- W, 16: sample width; fixed at 16 for this codec.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  run request; level-sensitive.
- s_data  in  W  sample from producer. Samples alternate left, right, left, and so on.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full; a transfer occurs when s_valid and s_ready are both high on a clock edge.
- bclk  out  1  serial bit clock, registered.
- lrclk  out  1  word select, registered; 0 = left slot, 1 = right slot.
- word_out  out  W  sample word for the shifter, registered.
- word_load  out  1  one-clk pulse; word_out is new this cycle.
- underrun  out  1  one-clk pulse; a slot started with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- States:
  - IDLE: bclk=0, lrclk=0, divider and bit counter held at 0.
  - RUN: clocks toggling.
  - DRAIN: enable has dropped; the current frame is finishing.
- Transitions:
  - IDLE→RUN when enable=1.
  - RUN→DRAIN when enable=0.
  - DRAIN→RUN if enable returns before the frame ends.
  - DRAIN→IDLE at the falling edge that ends the right slot, i.e. the bit counter wraps with lrclk=1.
- Divider: half_cnt counts 0..DIV-1. At DIV-1 it wraps to 0 and bclk toggles.
- Bit counter: bit_cnt (4 bits) advances on every falling-bclk event, 0..15, then wraps.
- Slot start: a falling-bclk event with bit_cnt wrapping to 0, or the first falling event after entering RUN. At each slot start:
  - lrclk is set to the slot side. The first slot after IDLE is left (lrclk=0); afterwards lrclk toggles each slot.
  - If the FIFO is non-empty: pop, word_out ← head, word_load=1.
  - If the FIFO is empty: word_out ← 0, word_load=1, underrun=1. See Configuration.
- FIFO:
  - s_ready = !full.
  - A write when full is impossible by handshake. A pop and a push in the same cycle are both honoured, and the level is unchanged.
  - There is no write-to-read bypass. A sample pushed in a slot-start cycle is not popped that cycle.
- Enable low in IDLE: the FIFO still accepts writes until full.
- Reset at any time:
  - The FIFO is flushed and fifo_level=0.
  - State returns to IDLE; all counters are 0.
  - Reset values of all outputs: bclk=0, lrclk=0, word_out=0, word_load=0, underrun=0, s_ready=1, fifo_level=0.

## Timing
- bclk period is 2·DIV clk; a slot is 16 bclk periods; a frame is 32 bclk = 64·DIV clk.
- Enable is sampled high at cycle 0. bclk rises at cycle DIV. The first falling edge, with word_load, lrclk=0 and the left sample, is at cycle 2·DIV.
- word_load, the new word_out, the new lrclk and bclk going low all appear on the same clk edge.
- word_out is stable for the whole slot (32·DIV clk).
- underrun and word_load are single-cycle pulses, never stretched.
- Pop latency: fifo_level decrements on the slot-start edge.

## Configuration
- I2S_FEED_HOLD_LAST_EN defined: on underrun, word_out repeats the last word loaded for the same channel (left or right). underrun still pulses. This needs two W-bit history registers, both cleared by reset.
- I2S_FEED_HOLD_LAST_EN undefined: on underrun, word_out is 0.

## Structure
- Shared package i2s_pkg:
  - sample width constant I2S_W=16;
  - bits-per-slot constant I2S_SLOT_BITS=16;
  - state enum {IDLE, RUN, DRAIN};
  - channel constants LEFT=0 and RIGHT=1.
- One sub-module: i2s_sample_fifo. It is a synchronous FIFO with parameters W and DEPTH; ports push, pop, din, dout (head, show-ahead), full, empty, level; same async reset.
- The clock generator and slot logic stay in the top level.

## Test plan
- DIV=4, push 0xA5A5 then 0x5A5A, raise enable → word_load at cycle 8 with word_out=0xA5A5, lrclk=0; second word_load at cycle 136 with 0x5A5A, lrclk=1; bclk period 8 clk.
- FIFO_DEPTH=4, push 5 samples back-to-back with enable=0 → s_ready low after 4 transfers, fifo_level=4, fifth sample held off until the first pop.
- Enable with an empty FIFO → underrun pulses at cycle 8 and word_out=0. With I2S_FEED_HOLD_LAST_EN defined, after a prior left sample 0x1234, word_out=0x1234 on a left-slot underrun.
- Drop enable mid-left-slot → bclk continues until the end of the right slot, then IDLE with bclk=0, lrclk=0; no further word_load.
- Assert reset mid-slot with 3 samples queued → all outputs at reset values immediately, fifo_level=0; after release and enable, the first slot is left with an underrun.
- Push and pop in the same cycle at fifo_level=2 → level stays 2 and the popped word equals the oldest sample.
